// File: rtl/instr_mem_sync.sv
// Writable instruction memory: self-fills with HALT_WORD after reset, accepts
// loader writes, then serves fetches through a registered request/valid/stall port.
module instr_mem_sync #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 64,
  parameter logic [DATA_W-1:0] NOP_WORD  = 32'h0000_0000,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hA800_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              fetch_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  output logic              prog_err,
  output logic              load_ready,
  output logic              run
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   BYTE_LIMIT = (ADDR_W + 1)'(4 * DEPTH);

  typedef enum logic [1:0] {
    S_INIT = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10
  } state_e;

  // Range check runs on the full byte address so high bits never alias onto a word.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < BYTE_LIMIT);
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we_s;
  logic [IDX_W-1:0]    mem_idx_s;
  logic [DATA_W-1:0]   mem_wdata_s;

  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                perr_q, perr_d;
  logic                ready_q, ready_d;
  logic                run_q, run_d;

  logic                fetch_acc_s;
  logic                fetch_ok_s;
  logic [IDX_W-1:0]    fetch_idx_s;

  assign fetch_acc_s = (state_q == S_RUN) && fetch_req && !fetch_stall;
  assign fetch_ok_s  = addr_ok(fetch_addr);
  assign fetch_idx_s = fetch_addr[IDX_W+1:2];

  // Phase sequencing, init sweep and loader write port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_idx_s   = cnt_q;
    mem_wdata_s = HALT_WORD;
    perr_d      = 1'b0;
    case (state_q)
      S_INIT: begin
        mem_we_s = 1'b1;
        cnt_d    = cnt_q + IDX_W'(1);
        perr_d   = prog_we;
        if (cnt_q == LAST_IDX) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_INIT;
        end
      end
      S_LOAD: begin
        if (prog_we && addr_ok(prog_addr)) begin
          mem_we_s    = 1'b1;
          mem_idx_s   = prog_addr[IDX_W+1:2];
          mem_wdata_s = prog_data;
          perr_d      = 1'b0;
        end else begin
          perr_d      = prog_we;
        end
        if (prog_done) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        perr_d = prog_we;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == S_LOAD);
    run_d   = (state_d == S_RUN);
  end

  // Fetch response: stall freezes the response registers exactly.
  always_comb begin
    instr_d = instr_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (fetch_acc_s) begin
      valid_d = 1'b1;
      if (fetch_ok_s) begin
        instr_d = mem_q[fetch_idx_s];
        ferr_d  = 1'b0;
      end else begin
        instr_d = NOP_WORD;
        ferr_d  = 1'b1;
      end
    end else if (fetch_stall) begin
      valid_d = valid_q;
      ferr_d  = ferr_q;
    end else begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ready_q <= ready_d;
      run_q   <= run_d;
    end
  end

  // Storage array; rst only suppresses writes, the init sweep does the clearing.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = ferr_q;
  assign prog_err    = perr_q;
  assign load_ready  = ready_q;
  assign run         = run_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: directed vector table plus randomized
// traffic compared every cycle against a phase-level reference model.
module tb_instr_mem_sync;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] HALT  = 32'hA800_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_stall = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_err;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = 32'h0;
  logic [31:0] prog_data = 32'h0;
  logic        prog_done = 1'b0;
  logic        prog_err;
  logic        load_ready;
  logic        run;

  instr_mem_sync #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP), .HALT_WORD(HALT)
  ) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
    .instr_out(instr_out), .instr_valid(instr_valid), .fetch_err(fetch_err),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_done(prog_done), .prog_err(prog_err),
    .load_ready(load_ready), .run(run)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = INIT, 1 = LOAD, 2 = RUN.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_instr = NOP;
  logic        e_valid = 1'b0;
  logic        e_err = 1'b0;
  logic        e_perr = 1'b0;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic        r;
    logic        req;
    logic [31:0] a;
    logic        st;
    logic        pwe;
    logic [31:0] pa;
    logic [31:0] pd;
    logic        pdn;
    logic [31:0] ei;
    logic        ev;
    logic        ee;
    logic        ep;
  } vec_t;

  vec_t tv[$];

  function automatic bit good(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a < 32'(4 * DEPTH));
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 4) != 0) return 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
    else return 32'($urandom);
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_phase = 0; m_cnt = 0;
      e_instr = NOP; e_valid = 1'b0; e_err = 1'b0; e_perr = 1'b0;
    end else begin
      e_perr = prog_we && !(m_phase == 1 && good(prog_addr));
      if (m_phase == 2 && fetch_req && !fetch_stall) begin
        e_valid = 1'b1;
        if (good(fetch_addr)) begin
          e_instr = m_mem[fetch_addr / 32'd4];
          e_err   = 1'b0;
        end else begin
          e_instr = NOP;
          e_err   = 1'b1;
        end
      end else if (!fetch_stall) begin
        e_valid = 1'b0;
        e_err   = 1'b0;
      end
      if (m_phase == 0) begin
        m_mem[m_cnt] = HALT;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_phase = 1;
          m_cnt   = 0;
        end
      end else if (m_phase == 1) begin
        if (prog_we && good(prog_addr)) m_mem[prog_addr / 32'd4] = prog_data;
        if (prog_done) m_phase = 2;
      end
    end
  endtask

  task automatic step(input logic r, input logic req, input logic [31:0] a, input logic st,
                      input logic pwe, input logic [31:0] pa, input logic [31:0] pd,
                      input logic pdn);
    rst = r; fetch_req = req; fetch_addr = a; fetch_stall = st;
    prog_we = pwe; prog_addr = pa; prog_data = pd; prog_done = pdn;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk32("instr_out", instr_out, e_instr);
    chk32("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
    chk32("fetch_err", {31'd0, fetch_err}, {31'd0, e_err});
    chk32("prog_err", {31'd0, prog_err}, {31'd0, e_perr});
    chk32("load_ready", {31'd0, load_ready}, {31'd0, 1'(m_phase == 1)});
    chk32("run", {31'd0, run}, {31'd0, 1'(m_phase == 2)});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_load(input string nm);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (!load_ready && n < 200);
    chk32(nm, 32'(n), 32'd64);
  endtask

  function automatic vec_t mk(input logic r, input logic req, input logic [31:0] a,
                              input logic st, input logic pwe, input logic [31:0] pa,
                              input logic [31:0] pd, input logic pdn, input logic [31:0] ei,
                              input logic ev, input logic ee, input logic ep);
    vec_t v;
    v.r = r; v.req = req; v.a = a; v.st = st; v.pwe = pwe; v.pa = pa; v.pd = pd;
    v.pdn = pdn; v.ei = ei; v.ev = ev; v.ee = ee; v.ep = ep;
    return v;
  endfunction

  initial begin
    logic        p_req;
    logic [31:0] p_addr;
    logic        req, st, pwe;
    logic [31:0] a;

    // Directed table, applied from LOAD with a freshly filled memory.
    tv.push_back(mk(0, 0, 32'h00,  0, 1, 32'h00, 32'h8001_060A, 0, NOP, 0, 0, 0));
    tv.push_back(mk(0, 0, 32'h00,  0, 1, 32'h03, 32'hDEAD_BEEF, 0, NOP, 0, 0, 1));
    tv.push_back(mk(0, 0, 32'h00,  0, 1, 32'h04, 32'h0401_0000, 1, NOP, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h10,  0, 0, 32'h00, 32'h0, 0, HALT, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h00,  0, 0, 32'h00, 32'h0, 0, 32'h8001_060A, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h04,  0, 0, 32'h00, 32'h0, 0, 32'h0401_0000, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h06,  0, 0, 32'h00, 32'h0, 0, NOP, 1, 1, 0));
    tv.push_back(mk(0, 1, 32'h100, 0, 0, 32'h00, 32'h0, 0, NOP, 1, 1, 0));
    tv.push_back(mk(0, 1, 32'hFC,  0, 0, 32'h00, 32'h0, 0, HALT, 1, 0, 0));
    tv.push_back(mk(0, 0, 32'h00,  0, 0, 32'h00, 32'h0, 0, HALT, 0, 0, 0));
    tv.push_back(mk(0, 1, 32'h00,  0, 0, 32'h00, 32'h0, 0, 32'h8001_060A, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h04,  1, 0, 32'h00, 32'h0, 0, 32'h8001_060A, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h04,  1, 0, 32'h00, 32'h0, 0, 32'h8001_060A, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h04,  1, 0, 32'h00, 32'h0, 0, 32'h8001_060A, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h04,  0, 0, 32'h00, 32'h0, 0, 32'h0401_0000, 1, 0, 0));
    tv.push_back(mk(0, 0, 32'h00,  0, 1, 32'h08, 32'h1234_5678, 0, 32'h0401_0000, 0, 0, 1));
    tv.push_back(mk(0, 1, 32'h08,  0, 0, 32'h00, 32'h0, 0, HALT, 1, 0, 0));
    tv.push_back(mk(0, 1, 32'h06,  0, 0, 32'h00, 32'h0, 0, NOP, 1, 1, 0));
    tv.push_back(mk(0, 1, 32'h08,  1, 0, 32'h00, 32'h0, 0, NOP, 1, 1, 0));
    tv.push_back(mk(1, 1, 32'h08,  1, 0, 32'h00, 32'h0, 0, NOP, 0, 0, 0));

    // Reset, abort INIT at cnt = 20 (with a dropped loader write), then full sweep.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) step(1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 32'h08, 32'h5555_AAAA, 1'b1);
      else idle();
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_load("init_len_after_abort");

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].req, tv[i].a, tv[i].st, tv[i].pwe, tv[i].pa, tv[i].pd, tv[i].pdn);
      chk32($sformatf("vec%0d_instr", i), instr_out, tv[i].ei);
      chk32($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, tv[i].ev});
      chk32($sformatf("vec%0d_ferr", i), {31'd0, fetch_err}, {31'd0, tv[i].ee});
      chk32($sformatf("vec%0d_perr", i), {31'd0, prog_err}, {31'd0, tv[i].ep});
    end
    wait_load("init_len_after_run_reset");

    // Random loader traffic (fetches must be ignored), then RUN.
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), 1'b0, 1'($urandom_range(0, 3) != 0),
           rnd_addr(), 32'($urandom), 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, rnd_addr(), 32'($urandom), 1'b1);

    // Random fetch traffic honouring the hold-while-stalled rule.
    p_req = 1'b0;
    p_addr = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (p_req) begin
        req = 1'b1;
        a   = p_addr;
      end else begin
        req = 1'($urandom_range(0, 3) != 0);
        a   = rnd_addr();
      end
      st  = 1'($urandom_range(0, 3) == 0);
      pwe = 1'($urandom_range(0, 15) == 0);
      step(1'b0, req, a, st, pwe, rnd_addr(), 32'($urandom), 1'($urandom_range(0, 7) == 0));
      p_req  = req && st;
      p_addr = a;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
